// File: rtl/beta_elastic_pipe_stage_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
//   upstream side  : in_valid, in_data, in_ready
//   downstream side: out_valid, out_data, out_new, out_ready
//   status         : occupancy (items held, 0..2)
// Modports:
//   slave  - the stage itself (consumes in_*, produces out_*)
//   master - whatever surrounds the stage (producer and consumer)
interface beta_elastic_pipe_stage_if #(
   parameter int unsigned PayloadWidth = 32
);
   logic                    in_valid;
   logic [PayloadWidth-1:0] in_data;
   logic                    in_ready;
   logic                    out_valid;
   logic [PayloadWidth-1:0] out_data;
   logic                    out_new;
   logic                    out_ready;
   logic [1:0]              occupancy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_new, occupancy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_new, occupancy
   );
endinterface

// File: rtl/beta_elastic_pipe_stage.sv
// Reusable elastic pipeline register with a 2-entry skid buffer.
// The head item sits in the main register and drives out_data; a second item
// can be parked in the skid register while downstream is stalled. in_ready is
// decoded from the state register only, so no combinational ready path crosses
// the stage.
//
// Ports:
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   pip_stall_i  pipeline stall: treated as out_ready = 0
//   pip_flush_i  pipeline flush: synchronous discard of all contents
//   pipe         handshake bundle (slave modport), see beta_elastic_pipe_stage_if
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | nothing held, main/skid hold no live item
// ONE   | head item in main, skid free
// FULL  | head item in main, next item in skid, in_ready low
module beta_elastic_pipe_stage #(
   parameter int unsigned PayloadWidth = 32,
   parameter bit          ZeroOnFlush  = 1'b1
) (
   input logic                         clk_i,
   input logic                         rstn_i,
   input logic                         pip_stall_i,
   input logic                         pip_flush_i,
   beta_elastic_pipe_stage_if.slave    pipe
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [PayloadWidth-1:0] main_q, main_d;
   logic [PayloadWidth-1:0] skid_q, skid_d;
   logic                    new_q, new_d;

   logic in_ready;
   logic out_valid;
   logic in_fire;
   logic out_fire;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = pipe.in_valid & in_ready;
   assign out_fire  = out_valid & pipe.out_ready & ~pip_stall_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         new_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         new_q   <= new_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      new_d   = 1'b0;

      if (pip_flush_i) begin
         // Flush wins over stall and both fires; an in_fire this cycle is lost.
         state_d = EMPTY;
         if (ZeroOnFlush) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  main_d  = pipe.in_data;
                  new_d   = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = pipe.in_data;
                  new_d  = 1'b1;
               end else if (in_fire) begin
                  state_d = FULL;
                  skid_d  = pipe.in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain can happen.
               if (out_fire) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  new_d   = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   assign pipe.in_ready  = in_ready;
   assign pipe.out_valid = out_valid;
   assign pipe.out_data  = main_q;
   assign pipe.out_new   = new_q;
   assign pipe.occupancy = (state_q == FULL) ? 2'd2 :
                           (state_q == ONE)  ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_beta_elastic_pipe_stage.sv
module tb_beta_elastic_pipe_stage;
   localparam int unsigned W = 32;

   logic clk_i = 1'b0;
   logic rstn_i = 1'b0;
   logic pip_stall_i = 1'b0;
   logic pip_flush_i = 1'b0;

   int checks = 0;
   int failures = 0;

   beta_elastic_pipe_stage_if #(.PayloadWidth(W)) bus ();

   beta_elastic_pipe_stage #(.PayloadWidth(W), .ZeroOnFlush(1'b1)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .pip_stall_i (pip_stall_i),
      .pip_flush_i (pip_flush_i),
      .pipe        (bus)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: the stage is a FIFO of at most two items.
   logic [W-1:0] mq[$];
   bit           m_new = 1'b0;
   bit           cmp_en = 1'b0;

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mq.delete();
         m_new = 1'b0;
      end else begin
         int  prev;
         bit  acc, drn;
         prev = mq.size();
         acc  = bus.in_valid && (prev < 2);
         drn  = (prev > 0) && bus.out_ready && !pip_stall_i;
         if (pip_flush_i) begin
            mq.delete();
            m_new = 1'b0;
         end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(bus.in_data);
            m_new = (mq.size() > 0) && (prev == 0 || drn);
         end
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: DUT against model every cycle, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (cmp_en && rstn_i) begin
         chk("model_valid", W'(bus.out_valid), W'(mq.size() > 0));
         chk("model_occ", W'(bus.occupancy), W'(mq.size()));
         chk("model_ready", W'(bus.in_ready), W'(mq.size() < 2));
         chk("model_new", W'(bus.out_new), W'(m_new));
         chk("ready_vs_occ", W'(bus.in_ready), W'(bus.occupancy != 2'd2));
         if (mq.size() > 0) chk("model_data", bus.out_data, mq[0]);
      end
   end

   task automatic drive(input bit v, input logic [W-1:0] d, input bit r,
                        input bit s, input bit f);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      pip_stall_i   = s;
      pip_flush_i   = f;
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      drive(0, '0, 0, 0, 0);
      repeat (3) @(negedge clk_i);
      chk("reset_valid", W'(bus.out_valid), 0);
      chk("reset_ready", W'(bus.in_ready), 1);
      chk("reset_data", bus.out_data, 0);
      chk("reset_occ", W'(bus.occupancy), 0);
      rstn_i = 1'b1;
      cmp_en = 1'b1;

      // Back-to-back stream at full rate.
      drive(1, 32'h11, 1, 0, 0); tick();
      chk("t1_d0", bus.out_data, 32'h11); chk("t1_n0", W'(bus.out_new), 1);
      chk("t1_o0", W'(bus.occupancy), 1);
      drive(1, 32'h22, 1, 0, 0); tick();
      chk("t1_d1", bus.out_data, 32'h22); chk("t1_n1", W'(bus.out_new), 1);
      drive(1, 32'h33, 1, 0, 0); tick();
      chk("t1_d2", bus.out_data, 32'h33); chk("t1_n2", W'(bus.out_new), 1);
      chk("t1_o2", W'(bus.occupancy), 1);
      drive(0, '0, 1, 0, 0); tick();
      chk("t1_drain", W'(bus.out_valid), 0);

      // Fill the skid entry, then drain in order.
      drive(1, 32'hA, 0, 0, 0); tick();
      drive(1, 32'hB, 0, 0, 0); tick();
      chk("t2_occ", W'(bus.occupancy), 2);
      chk("t2_rdy", W'(bus.in_ready), 0);
      chk("t2_head", bus.out_data, 32'hA);
      drive(0, '0, 0, 0, 0); tick();
      chk("t2_hold", bus.out_data, 32'hA);
      drive(0, '0, 1, 0, 0); tick();
      chk("t2_d1", bus.out_data, 32'hB); chk("t2_n1", W'(bus.out_new), 1);
      chk("t2_o1", W'(bus.occupancy), 1);
      tick();
      chk("t2_empty", W'(bus.out_valid), 0);

      // Stall holds the head stable.
      drive(1, 32'h5, 0, 0, 0); tick();
      chk("t3_new0", W'(bus.out_new), 1);
      drive(0, '0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_data", bus.out_data, 32'h5);
         chk("t3_valid", W'(bus.out_valid), 1);
         chk("t3_new", W'(bus.out_new), 0);
      end
      drive(0, '0, 1, 0, 0); tick();
      chk("t3_fired", W'(bus.out_valid), 0);

      // Flush while full discards everything, including the concurrent push.
      drive(1, 32'hA, 0, 0, 0); tick();
      drive(1, 32'hB, 0, 0, 0); tick();
      drive(1, 32'hC, 1, 0, 1); tick();
      chk("t4_occ", W'(bus.occupancy), 0);
      chk("t4_valid", W'(bus.out_valid), 0);
      chk("t4_data", bus.out_data, 0);
      chk("t4_rdy", W'(bus.in_ready), 1);
      drive(0, '0, 1, 0, 0); tick();
      chk("t4_noC", W'(bus.out_valid), 0);

      // Asynchronous reset between clock edges while full.
      drive(1, 32'hA, 0, 0, 0); tick();
      drive(1, 32'hB, 0, 0, 0); tick();
      drive(0, '0, 0, 0, 0);
      chk("t5_pre", W'(bus.occupancy), 2);
      #2 rstn_i = 1'b0;
      #1;
      chk("t5_valid", W'(bus.out_valid), 0);
      chk("t5_occ", W'(bus.occupancy), 0);
      chk("t5_data", bus.out_data, 0);
      chk("t5_rdy", W'(bus.in_ready), 1);
      chk("t5_new", W'(bus.out_new), 0);
      #1 rstn_i = 1'b1;
      @(negedge clk_i);

      // Random traffic against the model.
      for (int c = 0; c < 10000; c++) begin
         drive($urandom_range(99) < 70, $urandom, $urandom_range(99) < 70,
               $urandom_range(99) < 20, $urandom_range(99) < 2);
         tick();
      end
      drive(0, '0, 1, 0, 0);
      repeat (4) tick();
      chk("final_empty", W'(bus.out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
